// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the miniRV memory-mapped I/O bridge:
//   - default I/O page base (addr[31:12])
//   - register offsets within the I/O page (addr[11:0])
//   - bit positions inside the timer control register
//   - write-strobe bundle handed from the decoder to the timer
// -----------------------------------------------------------------------------
package mmio_pkg;

  localparam logic [19:0] IO_BASE_DEFAULT = 20'hfffff;

  localparam logic [11:0] OFF_SW     = 12'h000;
  localparam logic [11:0] OFF_LED    = 12'h001;
  localparam logic [11:0] OFF_DIG    = 12'h002;
  localparam logic [11:0] OFF_SW_CHG = 12'h003;
  localparam logic [11:0] OFF_TCNT   = 12'h004;
  localparam logic [11:0] OFF_TCMP   = 12'h005;
  localparam logic [11:0] OFF_TCTL   = 12'h006;

  localparam int TCTL_EN     = 0;
  localparam int TCTL_IRQ_EN = 1;
  localparam int TCTL_MATCH  = 2;

  // One-hot-or-zero write strobes for the timer registers.
  typedef struct packed {
    logic cnt;
    logic cmp;
    logic ctl;
  } tmr_wen_t;

endpackage

// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
// Compare/wrap timer with a sticky match flag and a level interrupt.
//   clk, rst   : clock, synchronous active-high reset
//   tmr_wen    : decoded write strobes for TCNT / TCMP / TCTL
//   wdata      : core write data
//   tcnt, tcmp : counter and compare registers (for read-back)
//   tctl       : {match, irq_en, en}
//   irq        : match & irq_en, combinational of flops
// -----------------------------------------------------------------------------
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int TMR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  tmr_wen_t         tmr_wen,
  input  logic [31:0]      wdata,
  output logic [TMR_W-1:0] tcnt,
  output logic [TMR_W-1:0] tcmp,
  output logic [2:0]       tctl,
  output logic             irq
);

  logic [TMR_W-1:0] tcnt_r;
  logic [TMR_W-1:0] tcmp_r;
  logic [TMR_W-1:0] tcnt_nxt_s;
  logic             en_r;
  logic             irq_en_r;
  logic             match_r;
  logic             match_nxt_s;
  logic             hit_s;

  // Counter and match-flag next state; core write beats wrap/increment,
  // a new match beats a W1C of the flag.
  always_comb begin
    hit_s       = en_r && (tcnt_r == tcmp_r);
    tcnt_nxt_s  = tcnt_r;
    match_nxt_s = match_r;
    if (tmr_wen.cnt) begin
      tcnt_nxt_s = wdata[TMR_W-1:0];
    end else if (hit_s) begin
      tcnt_nxt_s = {TMR_W{1'b0}};
    end else if (en_r) begin
      tcnt_nxt_s = tcnt_r + TMR_W'(1);
    end else begin
      tcnt_nxt_s = tcnt_r;
    end
    if (hit_s) begin
      match_nxt_s = 1'b1;
    end else if (tmr_wen.ctl && wdata[TCTL_MATCH]) begin
      match_nxt_s = 1'b0;
    end else begin
      match_nxt_s = match_r;
    end
  end

  // Timer register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_r   <= {TMR_W{1'b0}};
      tcmp_r   <= {TMR_W{1'b0}};
      en_r     <= 1'b0;
      irq_en_r <= 1'b0;
      match_r  <= 1'b0;
    end else begin
      tcnt_r  <= tcnt_nxt_s;
      match_r <= match_nxt_s;
      if (tmr_wen.cmp) begin
        tcmp_r <= wdata[TMR_W-1:0];
      end
      if (tmr_wen.ctl) begin
        en_r     <= wdata[TCTL_EN];
        irq_en_r <= wdata[TCTL_IRQ_EN];
      end
    end
  end

  assign tcnt = tcnt_r;
  assign tcmp = tcmp_r;
  assign tctl = {match_r, irq_en_r, en_r};
  assign irq  = match_r & irq_en_r;

endmodule

// File: rtl/mmio_bridge.sv
// -----------------------------------------------------------------------------
// mmio_bridge
// Memory-mapped I/O bridge between the miniRV core data port and DRAM / board
// I/O. addr[31:12]==IO_BASE selects the I/O page; everything else is DRAM.
//   clk, rst    : clock, synchronous active-high reset
//   addr, wen   : core data address and write enable
//   wdata       : core write data
//   rdata       : combinational read data (DRAM or I/O register)
//   dram_rdata  : DRAM read data
//   dram_wen    : DRAM write enable (wen outside the I/O page)
//   sw          : raw asynchronous switches
//   led, dig    : LED and 7-segment registers
//   irq         : timer interrupt level
// -----------------------------------------------------------------------------
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [19:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int          SW_W    = 24,
  parameter int          LED_W   = 24,
  parameter int          TMR_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             wen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [31:0]      dram_rdata,
  output logic             dram_wen,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic [31:0]      dig,
  output logic             irq
);

  logic             io_sel_s;
  logic             io_wen_s;
  logic [11:0]      offset_s;
  logic             led_we_s;
  logic             dig_we_s;
  logic             chg_we_s;
  tmr_wen_t         tmr_wen_s;

  logic [LED_W-1:0] led_r;
  logic [31:0]      dig_r;
  logic [SW_W-1:0]  s1_r;
  logic [SW_W-1:0]  s2_r;
  logic [SW_W-1:0]  s3_r;
  logic [1:0]       prime_r;
  logic [SW_W-1:0]  sw_chg_r;
  logic [SW_W-1:0]  sw_chg_nxt_s;
  logic [SW_W-1:0]  chg_clr_s;
  logic [SW_W-1:0]  chg_set_s;

  logic [TMR_W-1:0] tcnt_s;
  logic [TMR_W-1:0] tcmp_s;
  logic [2:0]       tctl_s;
  logic [31:0]      io_rdata_s;

  assign io_sel_s = (addr[31:12] == IO_BASE);
  assign io_wen_s = wen & io_sel_s;
  assign offset_s = addr[11:0];
  assign dram_wen = wen & ~io_sel_s;

  // Write decode: one strobe per register, all low unless an I/O write hits it.
  always_comb begin
    led_we_s  = 1'b0;
    dig_we_s  = 1'b0;
    chg_we_s  = 1'b0;
    tmr_wen_s = '{cnt: 1'b0, cmp: 1'b0, ctl: 1'b0};
    if (io_wen_s) begin
      case (offset_s)
        OFF_LED:    led_we_s      = 1'b1;
        OFF_DIG:    dig_we_s      = 1'b1;
        OFF_SW_CHG: chg_we_s      = 1'b1;
        OFF_TCNT:   tmr_wen_s.cnt = 1'b1;
        OFF_TCMP:   tmr_wen_s.cmp = 1'b1;
        OFF_TCTL:   tmr_wen_s.ctl = 1'b1;
        default:    led_we_s      = 1'b0;
      endcase
    end else begin
      led_we_s = 1'b0;
    end
  end

  // LED and 7-segment output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= {LED_W{1'b0}};
      dig_r <= 32'd0;
    end else begin
      if (led_we_s) begin
        led_r <= wdata[LED_W-1:0];
      end
      if (dig_we_s) begin
        dig_r <= wdata;
      end
    end
  end

  // Sticky change bits: W1C clear, new edge wins; edges are ignored until the
  // synchroniser chain has been refilled after reset (prime counter saturated).
  always_comb begin
    chg_clr_s    = chg_we_s ? wdata[SW_W-1:0] : {SW_W{1'b0}};
    chg_set_s    = (prime_r == 2'd3) ? (s2_r ^ s3_r) : {SW_W{1'b0}};
    sw_chg_nxt_s = (sw_chg_r & ~chg_clr_s) | chg_set_s;
  end

  // Switch synchroniser, edge-detect stage, prime counter and change register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r     <= {SW_W{1'b0}};
      s2_r     <= {SW_W{1'b0}};
      s3_r     <= {SW_W{1'b0}};
      prime_r  <= 2'd0;
      sw_chg_r <= {SW_W{1'b0}};
    end else begin
      s1_r     <= sw;
      s2_r     <= s1_r;
      s3_r     <= s2_r;
      sw_chg_r <= sw_chg_nxt_s;
      if (prime_r != 2'd3) begin
        prime_r <= prime_r + 2'd1;
      end
    end
  end

  mmio_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .tmr_wen (tmr_wen_s),
    .wdata   (wdata),
    .tcnt    (tcnt_s),
    .tcmp    (tcmp_s),
    .tctl    (tctl_s),
    .irq     (irq)
  );

  // I/O read mux; narrow registers are zero-extended, holes read 0.
  always_comb begin
    io_rdata_s = 32'd0;
    case (offset_s)
      OFF_SW:     io_rdata_s[SW_W-1:0]  = s2_r;
      OFF_LED:    io_rdata_s[LED_W-1:0] = led_r;
      OFF_DIG:    io_rdata_s            = dig_r;
      OFF_SW_CHG: io_rdata_s[SW_W-1:0]  = sw_chg_r;
      OFF_TCNT:   io_rdata_s[TMR_W-1:0] = tcnt_s;
      OFF_TCMP:   io_rdata_s[TMR_W-1:0] = tcmp_s;
      OFF_TCTL:   io_rdata_s[2:0]       = tctl_s;
      default:    io_rdata_s            = 32'd0;
    endcase
  end

  assign rdata = io_sel_s ? io_rdata_s : dram_rdata;
  assign led   = led_r;
  assign dig   = dig_r;

endmodule

// File: tb/tb_mmio_bridge.sv
// -----------------------------------------------------------------------------
// tb_mmio_bridge
// Directed stimulus pushes hand-computed expectations into a scoreboard queue;
// a monitor on the falling edge pops each entry and compares it with the
// selected DUT output.
// -----------------------------------------------------------------------------
module tb_mmio_bridge;

  localparam int K_RDATA = 0;
  localparam int K_DWEN  = 1;
  localparam int K_LED   = 2;
  localparam int K_DIG   = 3;
  localparam int K_IRQ   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] dram_rdata;
  logic        dram_wen;
  logic [23:0] sw;
  logic [23:0] led;
  logic [31:0] dig;
  logic        irq;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mmio_bridge #(
    .IO_BASE (20'hfffff),
    .SW_W    (24),
    .LED_W   (24),
    .TMR_W   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wen        (wen),
    .wdata      (wdata),
    .rdata      (rdata),
    .dram_rdata (dram_rdata),
    .dram_wen   (dram_wen),
    .sw         (sw),
    .led        (led),
    .dig        (dig),
    .irq        (irq)
  );

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RDATA: return rdata;
      K_DWEN:  return {31'd0, dram_wen};
      K_LED:   return {8'd0, led};
      K_DIG:   return dig;
      K_IRQ:   return {31'd0, irq};
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: drain every expectation issued during this cycle.
  chk_t        cur;
  logic [31:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      act = observe(cur.kind);
      checks = checks + 1;
      if (act !== cur.exp) begin
        failures = failures + 1;
        $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input string name, input logic [31:0] exp);
    chk_t c;
    c.kind = kind;
    c.name = name;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    wen  = 1'b0;
    expect_val(K_RDATA, name, exp);
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
    logic [19:0] page;
    page  = a[31:12];
    addr  = a;
    wen   = 1'b1;
    wdata = d;
    expect_val(K_DWEN, {name, "_dram_wen"}, (page == 20'hfffff) ? 32'd0 : 32'd1);
    tick();
    wen = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    addr       = 32'd0;
    wen        = 1'b0;
    wdata      = 32'd0;
    dram_rdata = 32'hcafef00d;
    sw         = 24'h5a5a5a;
    tick();
    sw = 24'ha5a5a5;
    tick();
    sw = 24'h0000f0;
    tick();
    expect_val(K_LED, "rst_led", 32'd0);
    expect_val(K_DIG, "rst_dig", 32'd0);
    expect_val(K_IRQ, "rst_irq", 32'd0);
    rst = 1'b0;

    // Reset state and priming.
    rd(32'hfffff001, 32'd0, "rst_led_rd");
    rd(32'hfffff002, 32'd0, "rst_dig_rd");
    rd(32'hfffff004, 32'd0, "rst_tcnt_rd");
    rd(32'hfffff000, 32'h0000f0, "sw_after_rst");
    rd(32'hfffff003, 32'd0, "chg_prime_masked");

    // DRAM routing.
    wr(32'hfffff003, 32'd0, "io_wr");
    wr(32'h00000010, 32'h11, "dram_wr");
    rd(32'h00000010, 32'hcafef00d, "dram_rd");
    rd(32'hfffff003, 32'd0, "chg_still0");

    // Switch sync and sticky change.
    sw = 24'h000000;
    repeat (4) tick();
    wr(32'hfffff003, 32'hffffffff, "chg_clr_all");
    rd(32'hfffff003, 32'd0, "chg_cleared");
    sw = 24'h000001;
    rd(32'hfffff000, 32'd0, "sw_sync0");
    rd(32'hfffff000, 32'd0, "sw_sync1");
    rd(32'hfffff000, 32'd1, "sw_sync2");
    rd(32'hfffff003, 32'd1, "chg_set");
    wr(32'hfffff003, 32'd1, "chg_w1c");
    rd(32'hfffff003, 32'd0, "chg_w1c_rd");
    sw = 24'h000003;
    rd(32'hfffff003, 32'd0, "chg_b1_wait0");
    rd(32'hfffff003, 32'd0, "chg_b1_wait1");
    wr(32'hfffff003, 32'd2, "chg_w1c_race");
    rd(32'hfffff003, 32'd2, "chg_new_wins");

    // LED / DIG registers and unmapped holes.
    wr(32'hfffff001, 32'h00abcdef, "led_wr");
    wr(32'hfffff002, 32'h12345678, "dig_wr");
    expect_val(K_LED, "led_out", 32'h00abcdef);
    expect_val(K_DIG, "dig_out", 32'h12345678);
    rd(32'hfffff001, 32'h00abcdef, "led_rd");
    rd(32'hfffff002, 32'h12345678, "dig_rd");
    wr(32'hfffff0ff, 32'h00000055, "hole_wr");
    rd(32'hfffff0ff, 32'd0, "hole_0ff_rd");
    rd(32'hfffff007, 32'd0, "hole_007_rd");
    expect_val(K_LED, "led_after_hole", 32'h00abcdef);
    tick();

    // Timer compare/wrap with TCMP=3.
    wr(32'hfffff005, 32'd3, "tcmp3");
    wr(32'hfffff006, 32'd3, "tctl_en");
    rd(32'hfffff004, 32'd0, "tcnt0");
    rd(32'hfffff004, 32'd1, "tcnt1");
    rd(32'hfffff004, 32'd2, "tcnt2");
    expect_val(K_IRQ, "irq_before_wrap", 32'd0);
    rd(32'hfffff004, 32'd3, "tcnt3");
    expect_val(K_IRQ, "irq_at_wrap", 32'd1);
    rd(32'hfffff004, 32'd0, "tcnt_wrap");
    wr(32'hfffff006, 32'd7, "match_w1c");
    expect_val(K_IRQ, "irq_cleared", 32'd0);
    rd(32'hfffff006, 32'd3, "tctl_cleared");
    wr(32'hfffff006, 32'd7, "match_w1c_race");
    expect_val(K_IRQ, "irq_set_wins", 32'd1);
    rd(32'hfffff006, 32'd7, "tctl_set_wins");

    // Core write to TCNT beats increment.
    wr(32'hfffff005, 32'd20, "tcmp20");
    wr(32'hfffff004, 32'd10, "tcnt_wr10");
    rd(32'hfffff004, 32'd10, "tcnt_wr_beats");
    rd(32'hfffff004, 32'd11, "tcnt_after_wr");
    rd(32'hfffff005, 32'd20, "tcmp_rd");

    // TCMP=0: match every cycle, TCNT pinned at 0.
    wr(32'hfffff006, 32'd7, "match_clr2");
    wr(32'hfffff005, 32'd0, "tcmp0");
    wr(32'hfffff004, 32'd0, "tcnt_wr0");
    rd(32'hfffff006, 32'd3, "tcmp0_nomatch_yet");
    rd(32'hfffff004, 32'd0, "tcmp0_cnt_a");
    rd(32'hfffff006, 32'd7, "tcmp0_match");
    rd(32'hfffff004, 32'd0, "tcmp0_cnt_b");

    // Natural all-ones wrap raises no flag.
    wr(32'hfffff005, 32'd5, "tcmp5");
    wr(32'hfffff006, 32'd7, "match_clr3");
    wr(32'hfffff004, 32'hffffffff, "tcnt_max");
    rd(32'hfffff004, 32'hffffffff, "tcnt_max_rd");
    rd(32'hfffff004, 32'd0, "tcnt_nat_wrap");
    rd(32'hfffff006, 32'd3, "nat_wrap_noflag");

    // Reset mid-operation, with a concurrent LED write.
    addr  = 32'hfffff001;
    wen   = 1'b1;
    wdata = 32'hffffffff;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    wen = 1'b0;
    expect_val(K_LED, "midrst_led", 32'd0);
    expect_val(K_IRQ, "midrst_irq", 32'd0);
    rd(32'hfffff000, 32'd0, "midrst_sw");
    rd(32'hfffff004, 32'd0, "midrst_tcnt");
    rd(32'hfffff006, 32'd0, "midrst_tctl");
    rd(32'hfffff005, 32'd0, "midrst_tcmp");
    rd(32'hfffff003, 32'd0, "midrst_chg");

    tick();
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
